// File: rtl/mdu_stall_source_if.sv
// mdu_stall_source_if: issue/result bundle between the E-stage MDU and the
// pipeline (issue side plus hazard unit).
//   E_Start    issue strobe, an MDU op is in E this cycle
//   E_MDOp     operation code (NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO/reserved)
//   E_A, E_B   rs / rt operands
//   E_HiLoSel  MFHI/MFLO read select, 1 = HI, 0 = LO
//   Busy       a mult/div operation is in flight (registered)
//   E_MDOut    combinational HI/LO read data
//   HI, LO     architectural HI/LO registers
// slave  = the MDU, master = the pipeline driving it.
interface mdu_stall_source_if;
  logic        E_Start;
  logic [2:0]  E_MDOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_HiLoSel;
  logic        Busy;
  logic [31:0] E_MDOut;
  logic [31:0] HI;
  logic [31:0] LO;

  modport slave (
    input  E_Start, E_MDOp, E_A, E_B, E_HiLoSel,
    output Busy, E_MDOut, HI, LO
  );

  modport master (
    output E_Start, E_MDOp, E_A, E_B, E_HiLoSel,
    input  Busy, E_MDOut, HI, LO
  );
endinterface

// File: rtl/mdu_stall_source.sv
// mdu_stall_source: multi-cycle multiply/divide unit in E, owning HI/LO and
// producing the Busy stall signal consumed by the hazard unit.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   mdu    slave side of mdu_stall_source_if (issue inputs, Busy, E_MDOut,
//          HI, LO)
// The result is computed at issue and parked in a shadow register; the
// counter only times the busy window, and {HI,LO} are written on the edge
// where the counter leaves 1. A divide by zero runs the full window but
// leaves HI/LO untouched.
module mdu_stall_source #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  mdu_stall_source_if.slave  mdu
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdop_e;

  // RUN is held exactly while the counter is non-zero.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] shadow_q, shadow_d;
  logic        wr_q, wr_d;       // commit shadow to HI/LO at completion
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  mdop_e       op;
  logic [31:0] a, b;

  assign op = mdop_e'(mdu.E_MDOp);
  assign a  = mdu.E_A;
  assign b  = mdu.E_B;

  // ---------------------------------------------------------------- datapath
  logic [63:0] mul_u, mul_s;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, qs_mag, rs_mag, qs, rs, qu, ru;

  // Signed product is the low 64 bits of the sign-extended 64x64 product.
  assign mul_u = {32'b0, a} * {32'b0, b};
  assign mul_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

  assign b_zero = (b == '0);
  assign a_neg  = a[31];
  assign b_neg  = b[31];
  assign a_mag  = a_neg ? (32'd0 - a) : a;
  assign b_mag  = b_neg ? (32'd0 - b) : b;

  // Signed divide on magnitudes: 0x80000000 / -1 yields magnitude
  // 0x80000000, which negates back to itself, so no trap case exists.
  always_comb begin
    qs_mag = '0;
    rs_mag = '0;
    qu     = '0;
    ru     = '0;
    if (!b_zero) begin
      qs_mag = a_mag / b_mag;
      rs_mag = a_mag % b_mag;
      qu     = a / b;
      ru     = a % b;
    end
  end

  assign qs = (a_neg ^ b_neg) ? (32'd0 - qs_mag) : qs_mag;
  assign rs = a_neg ? (32'd0 - rs_mag) : rs_mag;

  // ------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      wr_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      wr_q     <= wr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // ------------------------------------------------------ next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    wr_d     = wr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (mdu.E_Start) begin
          case (op)
            OP_MULT: begin
              state_d  = S_RUN;
              cnt_d    = MULT_N;
              shadow_d = mul_s;
              wr_d     = 1'b1;
            end
            OP_MULTU: begin
              state_d  = S_RUN;
              cnt_d    = MULT_N;
              shadow_d = mul_u;
              wr_d     = 1'b1;
            end
            OP_DIV: begin
              state_d  = S_RUN;
              cnt_d    = DIV_N;
              shadow_d = {rs, qs};
              wr_d     = !b_zero;
            end
            OP_DIVU: begin
              state_d  = S_RUN;
              cnt_d    = DIV_N;
              shadow_d = {ru, qu};
              wr_d     = !b_zero;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Any E_Start seen here is ignored; only the countdown advances.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          if (wr_q) begin
            hi_d = shadow_q[63:32];
            lo_d = shadow_q[31:0];
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------- output logic
  always_comb begin
    mdu.Busy    = (state_q == S_RUN);
    mdu.HI      = hi_q;
    mdu.LO      = lo_q;
    mdu.E_MDOut = mdu.E_HiLoSel ? hi_q : lo_q;
  end

endmodule
